// File: rtl/alu_seq_pkg.sv
// Shared definitions for the ALU operation sequencer: FSM encoding,
// ALU input-select codes and the reserved reset opcode.
package alu_seq_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_LOAD = 3'd1,
        ST_WAIT = 3'd2,
        ST_CLR  = 3'd3,
        ST_RESP = 3'd4
    } seq_state_e;

    localparam logic [2:0] SEL_PERSIST = 3'b100;
    localparam logic [2:0] SEL_LOAD    = 3'b010;
    localparam logic [2:0] SEL_RESET   = 3'b001;

    localparam logic [2:0] OP_RESET = 3'd7;

endpackage

// File: rtl/alu_op_decode.sv
// Maps a 3-bit opcode to the ALU's 7-bit one-hot operation select;
// op0 selects the MSB, and the reset opcode selects nothing.
module alu_op_decode
    import alu_seq_pkg::*;
(
    input  logic [2:0] op,
    output logic [6:0] one_hot
);

    // opcode to one-hot lookup
    always_comb begin
        one_hot = 7'b0000000;
        case (op)
            3'd0:     one_hot = 7'b1000000;
            3'd1:     one_hot = 7'b0100000;
            3'd2:     one_hot = 7'b0010000;
            3'd3:     one_hot = 7'b0001000;
            3'd4:     one_hot = 7'b0000100;
            3'd5:     one_hot = 7'b0000010;
            3'd6:     one_hot = 7'b0000001;
            OP_RESET: one_hot = 7'b0000000;
            default:  one_hot = 7'b0000000;
        endcase
    end

endmodule

// File: rtl/alu_op_sequencer.sv
// Drives the `main` ALU through its load/persist/reset sequence for each
// accepted command and returns the result. Optional counters: ALU_SEQ_STATS_EN.
module alu_op_sequencer
    import alu_seq_pkg::*;
#(
    parameter int ALU_LATENCY = 1,
    parameter int WIDTH       = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [WIDTH-1:0] cmd_a,
    input  logic [WIDTH-1:0] cmd_b,
    input  logic [2:0]       cmd_op,
    output logic             alu_on,
    output logic [2:0]       alu_in_sel,
    output logic [WIDTH-1:0] alu_num1,
    output logic [WIDTH-1:0] alu_num2,
    output logic [6:0]       alu_out_sel,
    input  logic [WIDTH-1:0] alu_out,
    input  logic [1:0]       alu_curr_state,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_data,
    output logic [1:0]       rsp_state,
    output logic [2:0]       rsp_op
`ifdef ALU_SEQ_STATS_EN
    ,
    output logic [15:0]      stat_ops,
    output logic [15:0]      stat_resets
`endif
);

    localparam logic [3:0] LAT_INIT = 4'(ALU_LATENCY);

    seq_state_e state_r;
    seq_state_e next_state_s;
    logic [3:0] cnt_r;
    logic [2:0] op_r;
    logic [6:0] one_hot_s;
    logic       accept_s;
    logic       cnt_done_s;
    logic       rsp_hs_s;

    alu_op_decode u_decode (
        .op      (cmd_op),
        .one_hot (one_hot_s)
    );

    assign accept_s   = (state_r == ST_IDLE) && cmd_valid && cmd_ready;
    assign cnt_done_s = (state_r == ST_WAIT) && (cnt_r == 4'd1);
    assign rsp_hs_s   = (state_r == ST_RESP) && rsp_valid && rsp_ready;

    // FSM state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // FSM next-state logic
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) begin
                    if (cmd_op == OP_RESET) begin
                        next_state_s = ST_CLR;
                    end else begin
                        next_state_s = ST_LOAD;
                    end
                end else begin
                    next_state_s = ST_IDLE;
                end
            end
            ST_LOAD: next_state_s = ST_WAIT;
            ST_WAIT: begin
                if (cnt_done_s) begin
                    next_state_s = ST_RESP;
                end else begin
                    next_state_s = ST_WAIT;
                end
            end
            ST_CLR:  next_state_s = ST_RESP;
            ST_RESP: begin
                if (rsp_ready) begin
                    next_state_s = ST_IDLE;
                end else begin
                    next_state_s = ST_RESP;
                end
            end
            default: next_state_s = ST_IDLE;
        endcase
    end

    // ALU control outputs, registered from the upcoming state so they line up with it
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            alu_on     <= 1'b0;
            cmd_ready  <= 1'b0;
            alu_in_sel <= SEL_RESET;
        end else begin
            alu_on    <= 1'b1;
            cmd_ready <= (next_state_s == ST_IDLE);
            case (next_state_s)
                ST_LOAD: alu_in_sel <= SEL_LOAD;
                ST_CLR:  alu_in_sel <= SEL_RESET;
                default: alu_in_sel <= SEL_PERSIST;
            endcase
        end
    end

    // operand capture at accept; presented to the ALU from LOAD onward
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            alu_num1    <= {WIDTH{1'b0}};
            alu_num2    <= {WIDTH{1'b0}};
            alu_out_sel <= 7'b0000000;
            op_r        <= 3'd0;
        end else if (accept_s) begin
            op_r <= cmd_op;
            if (cmd_op != OP_RESET) begin
                alu_num1    <= cmd_a;
                alu_num2    <= cmd_b;
                alu_out_sel <= one_hot_s;
            end
        end
    end

    // ALU latency counter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_r <= 4'd0;
        end else if (state_r == ST_LOAD) begin
            cnt_r <= LAT_INIT;
        end else if (state_r == ST_WAIT) begin
            cnt_r <= cnt_r - 4'd1;
        end
    end

    // response capture and handshake
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rsp_valid <= 1'b0;
            rsp_data  <= {WIDTH{1'b0}};
            rsp_state <= 2'd0;
            rsp_op    <= 3'd0;
        end else if (cnt_done_s) begin
            rsp_valid <= 1'b1;
            rsp_data  <= alu_out;
            rsp_state <= alu_curr_state;
            rsp_op    <= op_r;
        end else if (state_r == ST_CLR) begin
            rsp_valid <= 1'b1;
            rsp_data  <= {WIDTH{1'b0}};
            rsp_state <= alu_curr_state;
            rsp_op    <= op_r;
        end else if (rsp_hs_s) begin
            rsp_valid <= 1'b0;
        end
    end

`ifdef ALU_SEQ_STATS_EN
    // saturating completed-response counters, split by command kind
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stat_ops    <= 16'd0;
            stat_resets <= 16'd0;
        end else if (rsp_hs_s) begin
            if (rsp_op == OP_RESET) begin
                if (stat_resets != 16'hFFFF) begin
                    stat_resets <= stat_resets + 16'd1;
                end
            end else begin
                if (stat_ops != 16'hFFFF) begin
                    stat_ops <= stat_ops + 16'd1;
                end
            end
        end
    end
`endif

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Directed bench for alu_op_sequencer with a small registered ALU model;
// also checks the statistics counters when ALU_SEQ_STATS_EN is defined.
module tb_alu_op_sequencer;

    logic       clk = 1'b0;
    logic       rst;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [7:0] cmd_a;
    logic [7:0] cmd_b;
    logic [2:0] cmd_op;
    logic       alu_on;
    logic [2:0] alu_in_sel;
    logic [7:0] alu_num1;
    logic [7:0] alu_num2;
    logic [6:0] alu_out_sel;
    logic [7:0] alu_out;
    logic [1:0] alu_curr_state;
    logic       rsp_valid;
    logic       rsp_ready;
    logic [7:0] rsp_data;
    logic [1:0] rsp_state;
    logic [2:0] rsp_op;
`ifdef ALU_SEQ_STATS_EN
    logic [15:0] stat_ops;
    logic [15:0] stat_resets;
`endif

    int chk_cnt  = 0;
    int pass_cnt = 0;

    // hand-computed results for a=0x57, b=0x1A, ops 0..6
    logic [7:0] exp_tab [7] = '{8'h71, 8'h3D, 8'h12, 8'h5F, 8'h4D, 8'hA8, 8'h1A};

    alu_op_sequencer #(.ALU_LATENCY(1), .WIDTH(8)) dut (
        .clk            (clk),
        .rst            (rst),
        .cmd_valid      (cmd_valid),
        .cmd_ready      (cmd_ready),
        .cmd_a          (cmd_a),
        .cmd_b          (cmd_b),
        .cmd_op         (cmd_op),
        .alu_on         (alu_on),
        .alu_in_sel     (alu_in_sel),
        .alu_num1       (alu_num1),
        .alu_num2       (alu_num2),
        .alu_out_sel    (alu_out_sel),
        .alu_out        (alu_out),
        .alu_curr_state (alu_curr_state),
        .rsp_valid      (rsp_valid),
        .rsp_ready      (rsp_ready),
        .rsp_data       (rsp_data),
        .rsp_state      (rsp_state),
        .rsp_op         (rsp_op)
`ifdef ALU_SEQ_STATS_EN
        ,
        .stat_ops       (stat_ops),
        .stat_resets    (stat_resets)
`endif
    );

    always #5 clk = ~clk;

    // ALU stand-in: result and state update one edge after a LOAD or reset select
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            alu_out        <= 8'h00;
            alu_curr_state <= 2'b00;
        end else if (alu_in_sel == 3'b010) begin
            alu_curr_state <= 2'b10;
            case (alu_out_sel)
                7'b1000000: alu_out <= alu_num1 + alu_num2;
                7'b0100000: alu_out <= alu_num1 - alu_num2;
                7'b0010000: alu_out <= alu_num1 & alu_num2;
                7'b0001000: alu_out <= alu_num1 | alu_num2;
                7'b0000100: alu_out <= alu_num1 ^ alu_num2;
                7'b0000010: alu_out <= ~alu_num1;
                7'b0000001: alu_out <= alu_num2;
                default:    alu_out <= 8'hEE;
            endcase
        end else if (alu_in_sel == 3'b001) begin
            alu_out        <= 8'h00;
            alu_curr_state <= 2'b00;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        chk_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        logic [6:0] oh;
        rst       = 1'b1;
        cmd_valid = 1'b0;
        rsp_ready = 1'b0;
        cmd_a     = 8'h00;
        cmd_b     = 8'h00;
        cmd_op    = 3'd0;
        repeat (2) tick();

        check("rst_in_sel", 32'(alu_in_sel), 32'(3'b001));
        check("rst_alu_on", 32'(alu_on), 32'(1'b0));
        check("rst_cmd_ready", 32'(cmd_ready), 32'(1'b0));
        check("rst_rsp_valid", 32'(rsp_valid), 32'(1'b0));
        check("rst_out_sel", 32'(alu_out_sel), 32'(7'b0000000));
        check("rst_rsp_data", 32'(rsp_data), 32'(8'h00));

        rst = 1'b0;
        tick();
        check("rel_cmd_ready", 32'(cmd_ready), 32'(1'b1));
        check("rel_alu_on", 32'(alu_on), 32'(1'b1));
        check("rel_in_sel", 32'(alu_in_sel), 32'(3'b100));

        // basic op 0 with late operand change and response backpressure
        cmd_valid = 1'b1;
        cmd_a     = 8'h57;
        cmd_b     = 8'h1A;
        cmd_op    = 3'd0;
        tick();
        check("load_in_sel", 32'(alu_in_sel), 32'(3'b010));
        check("load_out_sel", 32'(alu_out_sel), 32'(7'b1000000));
        check("load_num1", 32'(alu_num1), 32'(8'h57));
        check("load_num2", 32'(alu_num2), 32'(8'h1A));
        check("load_cmd_ready", 32'(cmd_ready), 32'(1'b0));
        cmd_valid = 1'b0;
        cmd_a     = 8'hFF;
        cmd_b     = 8'hFF;
        tick();
        check("wait_in_sel", 32'(alu_in_sel), 32'(3'b100));
        check("wait_num1", 32'(alu_num1), 32'(8'h57));
        check("wait_rsp_valid", 32'(rsp_valid), 32'(1'b0));
        tick();
        check("basic_rsp_valid", 32'(rsp_valid), 32'(1'b1));
        check("basic_rsp_data", 32'(rsp_data), 32'(8'h71));
        check("basic_rsp_op", 32'(rsp_op), 32'(3'd0));
        check("basic_rsp_state", 32'(rsp_state), 32'(2'b10));
        for (int i = 0; i < 5; i++) begin
            tick();
            check("bp_rsp_valid", 32'(rsp_valid), 32'(1'b1));
            check("bp_rsp_data", 32'(rsp_data), 32'(8'h71));
            check("bp_cmd_ready", 32'(cmd_ready), 32'(1'b0));
        end
        rsp_ready = 1'b1;
        tick();
        check("hs_rsp_valid", 32'(rsp_valid), 32'(1'b0));
        check("hs_cmd_ready", 32'(cmd_ready), 32'(1'b1));

        // op sweep: cmd_valid and rsp_ready held high, one response per 4 cycles
        cmd_valid = 1'b1;
        cmd_a     = 8'h57;
        cmd_b     = 8'h1A;
        for (int k = 0; k < 7; k++) begin
            cmd_op = 3'(k);
            oh     = 7'b1000000 >> k;
            tick();
            check("sweep_in_sel", 32'(alu_in_sel), 32'(3'b010));
            check("sweep_out_sel", 32'(alu_out_sel), 32'(oh));
            tick();
            tick();
            check("sweep_rsp_valid", 32'(rsp_valid), 32'(1'b1));
            check("sweep_rsp_data", 32'(rsp_data), 32'(exp_tab[k]));
            check("sweep_rsp_op", 32'(rsp_op), 32'(k));
            tick();
            check("sweep_idle_valid", 32'(rsp_valid), 32'(1'b0));
            check("sweep_idle_in_sel", 32'(alu_in_sel), 32'(3'b100));
            check("sweep_idle_ready", 32'(cmd_ready), 32'(1'b1));
        end
        cmd_valid = 1'b0;

        // reset command
        cmd_valid = 1'b1;
        cmd_op    = 3'd7;
        tick();
        check("clr_in_sel", 32'(alu_in_sel), 32'(3'b001));
        check("clr_cmd_ready", 32'(cmd_ready), 32'(1'b0));
        cmd_valid = 1'b0;
        tick();
        check("clr_done_in_sel", 32'(alu_in_sel), 32'(3'b100));
        check("clr_rsp_valid", 32'(rsp_valid), 32'(1'b1));
        check("clr_rsp_data", 32'(rsp_data), 32'(8'h00));
        check("clr_rsp_op", 32'(rsp_op), 32'(3'd7));
        check("clr_rsp_state", 32'(rsp_state), 32'(2'b10));
        tick();
        check("clr_hs_valid", 32'(rsp_valid), 32'(1'b0));
`ifdef ALU_SEQ_STATS_EN
        check("stat_ops_8", 32'(stat_ops), 32'(16'd8));
        check("stat_resets_1", 32'(stat_resets), 32'(16'd1));
`endif

        // reset during WAIT aborts the command
        cmd_valid = 1'b1;
        cmd_a     = 8'h10;
        cmd_b     = 8'h20;
        cmd_op    = 3'd0;
        tick();
        cmd_valid = 1'b0;
        tick();
        rst = 1'b1;
        #1;
        check("mid_rst_in_sel", 32'(alu_in_sel), 32'(3'b001));
        check("mid_rst_alu_on", 32'(alu_on), 32'(1'b0));
        check("mid_rst_num1", 32'(alu_num1), 32'(8'h00));
        check("mid_rst_out_sel", 32'(alu_out_sel), 32'(7'b0000000));
        check("mid_rst_valid", 32'(rsp_valid), 32'(1'b0));
        tick();
        rst = 1'b0;
        tick();
        check("post_rst_valid", 32'(rsp_valid), 32'(1'b0));
        check("post_rst_ready", 32'(cmd_ready), 32'(1'b1));

        // command after abort completes normally
        cmd_valid = 1'b1;
        cmd_op    = 3'd1;
        tick();
        cmd_valid = 1'b0;
        tick();
        tick();
        check("after_rsp_valid", 32'(rsp_valid), 32'(1'b1));
        check("after_rsp_data", 32'(rsp_data), 32'(8'hF0));
        check("after_rsp_op", 32'(rsp_op), 32'(3'd1));
        check("after_rsp_state", 32'(rsp_state), 32'(2'b10));
        tick();
        check("after_hs_valid", 32'(rsp_valid), 32'(1'b0));
`ifdef ALU_SEQ_STATS_EN
        check("stat_ops_1", 32'(stat_ops), 32'(16'd1));
        check("stat_resets_0", 32'(stat_resets), 32'(16'd0));
`endif

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
